vga_timing_gen: RTL and testbench

Parametrised successor to the fixed 640x480 video sync generator. Every horizontal and vertical timing field is a parameter, as are the sync polarities. Adds a pixel-rate divider, a run/hold enable, start-of-line and start-of-frame strobes, a frame counter, and a programmable delay on sync/blank/visible. The delay aligns those signals with downstream pattern generators that have N cycles of latency. Sits between the clock domain root and the pattern/colour pipeline in the top-level.

---
 rtl/vga_timing_pkg.sv | 20 ++
 rtl/sync_delay_line.sv | 30 +++
 rtl/vga_timing_gen.sv | 139 +++++++++++++
 tb/tb_vga_timing_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 defaults, polarity constants and sync level helper
package vga_timing_pkg;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int POL_ACTIVE_LOW  = 0;
  localparam int POL_ACTIVE_HIGH = 1;

  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction
endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - DEPTH-stage shift register with reset value; wire-through when DEPTH=0
module sync_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);
  if (DEPTH == 0) begin : g_pass
    logic w_unused;
    assign w_unused = i_clk ^ i_rst;
    assign o_data   = i_data;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int i = 0; i < DEPTH; i++) r_pipe[i] <= RESET_VAL;
      end else begin
        r_pipe[0] <= i_data;
        for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign o_data = r_pipe[DEPTH-1];
  end
endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised video timing generator with pixel divider and delayed sync/blank
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int HSYNC_POL  = POL_ACTIVE_LOW,
  parameter int VSYNC_POL  = POL_ACTIVE_LOW,
  parameter int PIX_DIV    = 1,
  parameter int PIPE_DELAY = 0,
  parameter int POS_W      = 10,
  parameter int FRAME_W    = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  output logic               o_pix_stb,
  output logic [POS_W-1:0]   o_hpos,
  output logic [POS_W-1:0]   o_vpos,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_hblank,
  output logic               o_vblank,
  output logic               o_visible,
  output logic               o_sol,
  output logic               o_sof,
  output logic [FRAME_W-1:0] o_frame_count
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  if (H_TOTAL > (2 ** POS_W)) begin : g_err_h
    $error("vga_timing_gen: H_TOTAL does not fit in POS_W");
  end
  if (V_TOTAL > (2 ** POS_W)) begin : g_err_v
    $error("vga_timing_gen: V_TOTAL does not fit in POS_W");
  end
  if (PIX_DIV < 1) begin : g_err_div
    $error("vga_timing_gen: PIX_DIV must be >= 1");
  end
  if (PIPE_DELAY > 15 || PIPE_DELAY < 0) begin : g_err_pipe
    $error("vga_timing_gen: PIPE_DELAY must be 0..15");
  end

  // Window bounds kept 32 bits wide so an end bound equal to 2^POS_W still compares correctly
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [31:0] H_LAST   = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_LAST   = 32'(V_TOTAL - 1);
  localparam logic [31:0] H_VIS    = 32'(H_VISIBLE);
  localparam logic [31:0] V_VIS    = 32'(V_VISIBLE);
  localparam logic [31:0] HS_START = 32'(H_VISIBLE + H_FRONT);
  localparam logic [31:0] HS_END   = 32'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [31:0] VS_START = 32'(V_VISIBLE + V_FRONT);
  localparam logic [31:0] VS_END   = 32'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic        HS_ACT   = 1'(HSYNC_POL);
  localparam logic        VS_ACT   = 1'(VSYNC_POL);

  logic [DIV_W-1:0]   r_div;
  logic [POS_W-1:0]   r_h_cnt, r_v_cnt;
  logic [FRAME_W-1:0] r_frame;
  logic               r_pix_stb, r_sol, r_sof;
  logic [POS_W-1:0]   r_hpos, r_vpos;
  logic               r_hsync, r_vsync, r_hblank, r_vblank, r_visible;

  logic [31:0] w_h, w_v;
  logic        w_tick, w_h_wrap, w_v_wrap, w_hs_act, w_vs_act;

  assign w_h      = 32'(r_h_cnt);
  assign w_v      = 32'(r_v_cnt);
  assign w_tick   = i_enable && (r_div == DIV_LAST);
  assign w_h_wrap = (w_h == H_LAST);
  assign w_v_wrap = (w_v == V_LAST);
  assign w_hs_act = (w_h >= HS_START) && (w_h < HS_END);
  assign w_vs_act = (w_v >= VS_START) && (w_v < VS_END);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div     <= '0;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_frame   <= '0;
      r_pix_stb <= 1'b0;
      r_sol     <= 1'b0;
      r_sof     <= 1'b0;
      r_hpos    <= '0;
      r_vpos    <= '0;
      r_hsync   <= ~HS_ACT;
      r_vsync   <= ~VS_ACT;
      r_hblank  <= 1'b1;
      r_vblank  <= 1'b1;
      r_visible <= 1'b0;
    end else begin
      // Strobes are recomputed every clock so they never stretch across divided pixels
      r_pix_stb <= w_tick;
      r_sol     <= w_tick && (w_h == 32'd0);
      r_sof     <= w_tick && (w_h == 32'd0) && (w_v == 32'd0);
      if (i_enable) r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_hpos    <= r_h_cnt;
        r_vpos    <= r_v_cnt;
        r_hsync   <= sync_level(w_hs_act, HS_ACT);
        r_vsync   <= sync_level(w_vs_act, VS_ACT);
        r_hblank  <= (w_h >= H_VIS);
        r_vblank  <= (w_v >= V_VIS);
        r_visible <= (w_h < H_VIS) && (w_v < V_VIS);
        r_h_cnt   <= w_h_wrap ? '0 : r_h_cnt + 1'b1;
        if (w_h_wrap) begin
          r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
          if (w_v_wrap) r_frame <= r_frame + 1'b1;
        end
      end
    end
  end

  sync_delay_line #(
    .WIDTH    (5),
    .DEPTH    (PIPE_DELAY),
    .RESET_VAL({~HS_ACT, ~VS_ACT, 3'b110})
  ) u_delay (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_data({r_hsync, r_vsync, r_hblank, r_vblank, r_visible}),
    .o_data({o_hsync, o_vsync, o_hblank, o_vblank, o_visible})
  );

  assign o_pix_stb     = r_pix_stb;
  assign o_sol         = r_sol;
  assign o_sof         = r_sof;
  assign o_hpos        = r_hpos;
  assign o_vpos        = r_vpos;
  assign o_frame_count = r_frame;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench on a 16x10 raster: plain instance A and divided/delayed instance B
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b0;
  logic en_b = 1'b0;

  logic       a_pix_stb, a_hsync, a_vsync, a_hblank, a_vblank, a_visible, a_sol, a_sof;
  logic [3:0] a_hpos, a_vpos;
  logic [1:0] a_frame_count;
  logic       b_pix_stb, b_hsync, b_vsync, b_hblank, b_vblank, b_visible, b_sol, b_sof;
  logic [4:0] b_hpos, b_vpos;
  logic [7:0] b_frame_count;

  int tot = 0;
  int bad = 0;
  // A model: next position to present (nh,nv), presented position (ph,pv)
  int nh = 0, nv = 0, ph = 0, pv = 0, msof = 0, a_clk = 0;
  bit a_tick = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(0), .VSYNC_POL(0), .PIX_DIV(1), .PIPE_DELAY(0),
    .POS_W(4), .FRAME_W(2)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_enable(en_a),
    .o_pix_stb(a_pix_stb), .o_hpos(a_hpos), .o_vpos(a_vpos),
    .o_hsync(a_hsync), .o_vsync(a_vsync), .o_hblank(a_hblank), .o_vblank(a_vblank),
    .o_visible(a_visible), .o_sol(a_sol), .o_sof(a_sof), .o_frame_count(a_frame_count)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1), .VSYNC_POL(0), .PIX_DIV(4), .PIPE_DELAY(3),
    .POS_W(5), .FRAME_W(8)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_enable(en_b),
    .o_pix_stb(b_pix_stb), .o_hpos(b_hpos), .o_vpos(b_vpos),
    .o_hsync(b_hsync), .o_vsync(b_vsync), .o_hblank(b_hblank), .o_vblank(b_vblank),
    .o_visible(b_visible), .o_sol(b_sol), .o_sof(b_sof), .o_frame_count(b_frame_count)
  );

  task automatic cyc();
    @(posedge clk);
    a_tick = en_a;
    if (a_tick) begin
      ph = nh;
      pv = nv;
      if (nh == 15) begin
        nh = 0;
        nv = (nv == 9) ? 0 : nv + 1;
      end else begin
        nh++;
      end
      if (ph == 0 && pv == 0) msof++;
    end
    a_clk++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tot++; if (a_hpos !== 4'd0 || a_vpos !== 4'd0) begin bad++; $display("FAIL reset_pos got=%0d,%0d exp=0,0", a_hpos, a_vpos); end
    tot++; if ({a_hblank, a_vblank, a_visible} !== 3'b110) begin bad++; $display("FAIL reset_blank got=%b exp=110", {a_hblank, a_vblank, a_visible}); end
    tot++; if ({a_hsync, a_vsync} !== 2'b11) begin bad++; $display("FAIL reset_sync_a got=%b exp=11", {a_hsync, a_vsync}); end
    tot++; if ({b_hsync, b_vsync} !== 2'b01) begin bad++; $display("FAIL reset_sync_b got=%b exp=01", {b_hsync, b_vsync}); end
    tot++; if ({a_pix_stb, a_sol, a_sof} !== 3'b000 || a_frame_count !== 2'd0) begin bad++; $display("FAIL reset_strobes got=%b fc=%0d exp=000 fc=0", {a_pix_stb, a_sol, a_sof}, a_frame_count); end
  endtask

  task automatic test_first_tick();
    rst = 1'b0;
    en_a = 1'b1;
    cyc();
    tot++; if ({a_pix_stb, a_sof, a_sol, a_visible} !== 4'b1111) begin bad++; $display("FAIL first_tick_flags got=%b exp=1111", {a_pix_stb, a_sof, a_sol, a_visible}); end
    tot++; if (a_hpos !== 4'd0 || a_vpos !== 4'd0) begin bad++; $display("FAIL first_tick_pos got=%0d,%0d exp=0,0", a_hpos, a_vpos); end
    repeat (16) cyc();
    tot++; if (a_hpos !== 4'd0 || a_vpos !== 4'd1) begin bad++; $display("FAIL line1_pos got=%0d,%0d exp=0,1", a_hpos, a_vpos); end
    tot++; if ({a_sol, a_sof} !== 2'b10) begin bad++; $display("FAIL line1_sol_sof got=%b exp=10", {a_sol, a_sof}); end
  endtask

  task automatic test_sync_windows();
    int hs_low = 0;
    int vs_low = 0;
    for (int i = 0; i < 160; i++) begin
      cyc();
      if (a_hsync === 1'b0) hs_low++;
      if (a_vsync === 1'b0) vs_low++;
      tot++; if (a_hpos !== 4'(ph) || a_vpos !== 4'(pv)) begin bad++; $display("FAIL sync_pos got=%0d,%0d exp=%0d,%0d", a_hpos, a_vpos, ph, pv); end
      tot++; if (a_hsync !== ((ph >= 10 && ph < 13) ? 1'b0 : 1'b1)) begin bad++; $display("FAIL hsync_window h=%0d got=%b", ph, a_hsync); end
      tot++; if (a_vsync !== ((pv >= 7 && pv < 9) ? 1'b0 : 1'b1)) begin bad++; $display("FAIL vsync_window v=%0d got=%b", pv, a_vsync); end
      tot++; if (a_visible !== ((ph < 8 && pv < 6) ? 1'b1 : 1'b0)) begin bad++; $display("FAIL visible h=%0d v=%0d got=%b", ph, pv, a_visible); end
      tot++; if (a_sol !== (ph == 0) || a_sof !== (ph == 0 && pv == 0)) begin bad++; $display("FAIL sol_sof h=%0d v=%0d got=%b%b", ph, pv, a_sol, a_sof); end
    end
    tot++; if (hs_low != 30) begin bad++; $display("FAIL hsync_low_count got=%0d exp=30", hs_low); end
    tot++; if (vs_low != 32) begin bad++; $display("FAIL vsync_low_count got=%0d exp=32", vs_low); end
  endtask

  task automatic test_frames();
    int prev = -1;
    for (int i = 0; i < 700 && msof < 5; i++) begin
      cyc();
      if (a_tick && ph == 0 && pv == 0) begin
        tot++; if (a_sof !== 1'b1) begin bad++; $display("FAIL frame_sof got=%b exp=1", a_sof); end
        tot++; if (a_frame_count !== 2'((msof - 1) % 4)) begin bad++; $display("FAIL frame_count sof#%0d got=%0d exp=%0d", msof, a_frame_count, (msof - 1) % 4); end
        if (prev >= 0) begin
          tot++; if (a_clk - prev != 160) begin bad++; $display("FAIL sof_spacing got=%0d exp=160", a_clk - prev); end
        end
        prev = a_clk;
      end
    end
    tot++; if (msof < 5) begin bad++; $display("FAIL frames_timeout got=%0d sofs exp=5", msof); end
    tot++; if (a_frame_count !== 2'd0) begin bad++; $display("FAIL frame_wrap got=%0d exp=0", a_frame_count); end
  endtask

  task automatic test_enable_hold();
    logic exp_hs;
    for (int i = 0; i < 200 && !(a_tick && ph == 5); i++) cyc();
    tot++; if (!(a_tick && ph == 5)) begin bad++; $display("FAIL hold_seek_timeout got=%0d exp=5", ph); end
    exp_hs = (ph >= 10 && ph < 13) ? 1'b0 : 1'b1;
    en_a = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      tot++; if (a_hpos !== 4'd5 || a_vpos !== 4'(pv)) begin bad++; $display("FAIL hold_pos got=%0d,%0d exp=5,%0d", a_hpos, a_vpos, pv); end
      tot++; if ({a_pix_stb, a_sol, a_sof} !== 3'b000) begin bad++; $display("FAIL hold_strobes got=%b exp=000", {a_pix_stb, a_sol, a_sof}); end
      tot++; if (a_hsync !== exp_hs || a_visible !== (pv < 6)) begin bad++; $display("FAIL hold_levels got=%b%b", a_hsync, a_visible); end
    end
    en_a = 1'b1;
    cyc();
    tot++; if (a_hpos !== 4'd6 || a_pix_stb !== 1'b1) begin bad++; $display("FAIL resume got=%0d stb=%b exp=6 stb=1", a_hpos, a_pix_stb); end
  endtask

  task automatic test_pix_div();
    int lat = 0;
    int hs_cnt = 0;
    int j;
    logic e_vis, e_hb, e_hs;
    en_b = 1'b1;
    while (b_pix_stb !== 1'b1 && lat < 10) begin
      cyc();
      lat++;
    end
    tot++; if (lat != 4) begin bad++; $display("FAIL div_first_tick got=%0d exp=4", lat); end
    for (int k = 0; k <= 70; k++) begin
      if (k > 0) cyc();
      if (k < 64 && b_hsync === 1'b1) hs_cnt++;
      j = k - 3;
      e_vis = (k >= 3) && ((j / 4) % 16 < 8);
      e_hb  = (k < 3) || ((j / 4) % 16 >= 8);
      e_hs  = (k >= 3) && ((j / 4) % 16 >= 10) && ((j / 4) % 16 < 13);
      tot++; if (b_pix_stb !== (k % 4 == 0)) begin bad++; $display("FAIL div_stb k=%0d got=%b", k, b_pix_stb); end
      tot++; if (b_hpos !== 5'((k / 4) % 16) || b_vpos !== 5'(k / 64)) begin bad++; $display("FAIL div_pos k=%0d got=%0d,%0d exp=%0d,%0d", k, b_hpos, b_vpos, (k / 4) % 16, k / 64); end
      tot++; if (b_sol !== ((k % 4 == 0) && ((k / 4) % 16 == 0))) begin bad++; $display("FAIL div_sol k=%0d got=%b", k, b_sol); end
      tot++; if (b_visible !== e_vis || b_hblank !== e_hb) begin bad++; $display("FAIL delay_vis k=%0d got=%b%b exp=%b%b", k, b_visible, b_hblank, e_vis, e_hb); end
      tot++; if (b_hsync !== e_hs || b_vblank !== (k < 3)) begin bad++; $display("FAIL delay_sync k=%0d got=%b%b exp=%b%b", k, b_hsync, b_vblank, e_hs, k < 3); end
    end
    tot++; if (hs_cnt != 12) begin bad++; $display("FAIL div_hsync_width got=%0d exp=12", hs_cnt); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 200 && !(a_tick && pv == 3 && ph == 2); i++) cyc();
    tot++; if (!(a_tick && pv == 3 && ph == 2)) begin bad++; $display("FAIL rst_seek_timeout got=%0d,%0d exp=2,3", ph, pv); end
    rst = 1'b1;
    en_a = 1'b0;
    #1;
    tot++; if (a_hpos !== 4'd0 || a_vpos !== 4'd0 || a_frame_count !== 2'd0) begin bad++; $display("FAIL async_rst_pos got=%0d,%0d fc=%0d exp=0,0,0", a_hpos, a_vpos, a_frame_count); end
    tot++; if ({a_hsync, a_vsync, a_hblank, a_vblank, a_visible} !== 5'b11110) begin bad++; $display("FAIL async_rst_a got=%b exp=11110", {a_hsync, a_vsync, a_hblank, a_vblank, a_visible}); end
    tot++; if ({b_hsync, b_vsync, b_hblank, b_vblank, b_visible} !== 5'b01110 || b_hpos !== 5'd0) begin bad++; $display("FAIL async_rst_b got=%b hpos=%0d exp=01110 hpos=0", {b_hsync, b_vsync, b_hblank, b_vblank, b_visible}, b_hpos); end
    @(negedge clk);
    nh = 0; nv = 0; msof = 0;
    rst = 1'b0;
    en_a = 1'b1;
    cyc();
    tot++; if (a_hpos !== 4'd0 || a_vpos !== 4'd0 || {a_sof, a_pix_stb} !== 2'b11) begin bad++; $display("FAIL post_rst_tick got=%0d,%0d sof_stb=%b exp=0,0,11", a_hpos, a_vpos, {a_sof, a_pix_stb}); end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_sync_windows();
    test_frames();
    test_enable_hold();
    test_pix_div();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
